// File: rtl/axi_node_pkg.sv
// ---------------------------------------------------------------------------
// axi_node_pkg
// Shared definitions for the AXI node read/write data paths.
//   RESP_W        : width of an AXI RRESP/BRESP field.
//   DEF_*         : default node widths, used as parameter defaults.
//   r_beat_t      : one R-channel beat at the default widths, including the
//                   routing destination that selects the target port.
// ---------------------------------------------------------------------------
package axi_node_pkg;

  localparam int RESP_W         = 2;

  localparam int DEF_ID_IN      = 4;
  localparam int DEF_USER_W     = 6;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_N_TARG     = 7;
  localparam int DEF_LOG_N_TARG = $clog2(DEF_N_TARG);

  typedef struct packed {
    logic [DEF_LOG_N_TARG-1:0] dest;
    logic [DEF_ID_IN-1:0]      id;
    logic [DEF_DATA_W-1:0]     data;
    logic [RESP_W-1:0]         resp;
    logic                      last;
    logic [DEF_USER_W-1:0]     user;
  } r_beat_t;

endpackage

// File: rtl/axi_dr_router_if.sv
// ---------------------------------------------------------------------------
// axi_dr_router_if
// Bundles the R-channel signals around the read-data return router.
//   rid_i .. rvalid_i, rready_o : single slave-side R channel (ID carries
//                                 the routing field in its upper bits).
//   rid_o .. rvalid_o, rready_i : per-target-port R channels; payload is
//                                 broadcast, rvalid_o is one-hot.
//   drop_cnt_o, route_err_o     : out-of-range destination status.
// Modport slave is taken by the router, modport master by its environment.
// ---------------------------------------------------------------------------
interface axi_dr_router_if
  import axi_node_pkg::*;
#(
  parameter int AXI_ID_IN   = DEF_ID_IN,
  parameter int AXI_USER_W  = DEF_USER_W,
  parameter int AXI_DATA_W  = DEF_DATA_W,
  parameter int N_TARG_PORT = DEF_N_TARG,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG
) ();

  logic [AXI_ID_OUT-1:0]                     rid_i;
  logic [AXI_DATA_W-1:0]                     rdata_i;
  logic [RESP_W-1:0]                         rresp_i;
  logic                                      rlast_i;
  logic [AXI_USER_W-1:0]                     ruser_i;
  logic                                      rvalid_i;
  logic                                      rready_o;

  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]     rid_o;
  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]    rdata_o;
  logic [N_TARG_PORT-1:0][RESP_W-1:0]        rresp_o;
  logic [N_TARG_PORT-1:0]                    rlast_o;
  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]    ruser_o;
  logic [N_TARG_PORT-1:0]                    rvalid_o;
  logic [N_TARG_PORT-1:0]                    rready_i;

  logic [7:0]                                drop_cnt_o;
  logic                                      route_err_o;

  modport slave (
    input  rid_i, rdata_i, rresp_i, rlast_i, ruser_i, rvalid_i,
    output rready_o,
    output rid_o, rdata_o, rresp_o, rlast_o, ruser_o, rvalid_o,
    input  rready_i,
    output drop_cnt_o, route_err_o
  );

  modport master (
    output rid_i, rdata_i, rresp_i, rlast_i, ruser_i, rvalid_i,
    input  rready_o,
    input  rid_o, rdata_o, rresp_o, rlast_o, ruser_o, rvalid_o,
    output rready_i,
    input  drop_cnt_o, route_err_o
  );

endinterface

// File: rtl/axi_r_spill_buffer.sv
// ---------------------------------------------------------------------------
// axi_r_spill_buffer
// Two-entry valid/ready buffer. i_ready never reaches o_ready
// combinationally: o_ready depends only on the registered occupancy.
//   clk, rst_n       : clock, asynchronous active-low reset.
//   i_data, i_valid  : upstream beat; accepted when i_valid & o_ready.
//   o_ready          : buffer not full.
//   o_data, o_valid  : head entry, valid while the buffer is non-empty.
//   i_ready          : downstream ready; pops the head when o_valid.
// ---------------------------------------------------------------------------
module axi_r_spill_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
);

  logic [1:0]            r_count;
  logic                  r_wrPtr;
  logic                  r_rdPtr;
  logic [DATA_WIDTH-1:0] r_mem [2];

  logic w_push;
  logic w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rdPtr];
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  // Occupancy and pointers. A push and a pop in the same cycle leave the
  // count unchanged, which is what gives one beat per cycle at count 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= ~r_wrPtr;
      if (w_pop)  r_rdPtr <= ~r_rdPtr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  // Payload storage; contents are qualified by r_count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/axi_dr_router.sv
// ---------------------------------------------------------------------------
// axi_dr_router
// Read-data return router: steers each slave-side R beat to the target port
// named by the upper LOG_N_TARG bits of RID, through a 2-entry spill buffer.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : axi_dr_router_if.slave
//                slave-side R channel in, per-port R channels out (payload
//                broadcast, one-hot rvalid_o), drop counter and sticky error
//                for beats whose destination is not an existing port.
// ---------------------------------------------------------------------------
module axi_dr_router
  import axi_node_pkg::*;
#(
  parameter int AXI_ID_IN   = DEF_ID_IN,
  parameter int AXI_USER_W  = DEF_USER_W,
  parameter int AXI_DATA_W  = DEF_DATA_W,
  parameter int N_TARG_PORT = DEF_N_TARG,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG
) (
  input  logic            clk,
  input  logic            rst_n,
  axi_dr_router_if.slave  bus
);

  typedef struct packed {
    logic [LOG_N_TARG-1:0] dest;
    logic [AXI_ID_IN-1:0]  id;
    logic [AXI_DATA_W-1:0] data;
    logic [RESP_W-1:0]     resp;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  beat_t             w_inBeat;
  beat_t             w_head;
  logic [BEAT_W-1:0] w_headBits;
  logic              w_inRange;
  logic              w_bufReady;
  logic              w_headValid;
  logic              w_popReady;
  logic              w_drop;

  logic [7:0]        r_dropCnt;
  logic              r_routeErr;

  assign w_inBeat.dest = bus.rid_i[AXI_ID_OUT-1:AXI_ID_IN];
  assign w_inBeat.id   = bus.rid_i[AXI_ID_IN-1:0];
  assign w_inBeat.data = bus.rdata_i;
  assign w_inBeat.resp = bus.rresp_i;
  assign w_inBeat.last = bus.rlast_i;
  assign w_inBeat.user = bus.ruser_i;

  // Out-of-range beats are still handshaken upstream but never stored.
  assign w_inRange    = (int'(w_inBeat.dest) < N_TARG_PORT);
  assign w_drop       = bus.rvalid_i & w_bufReady & ~w_inRange;
  assign bus.rready_o = w_bufReady;

  // Only the addressed port's ready can pop; rvalid_o is one-hot so the
  // reduction picks exactly that port.
  assign w_popReady = |(bus.rvalid_o & bus.rready_i);
  assign w_head     = beat_t'(w_headBits);

  axi_r_spill_buffer #(
    .DATA_WIDTH (BEAT_W)
  ) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (w_inBeat),
    .i_valid (bus.rvalid_i & w_inRange),
    .o_ready (w_bufReady),
    .o_data  (w_headBits),
    .o_valid (w_headValid),
    .i_ready (w_popReady)
  );

  // Destination decode of the buffer head into a one-hot valid.
  always_comb begin
    bus.rvalid_o = '0;
    for (int k = 0; k < N_TARG_PORT; k++) begin
      bus.rvalid_o[k] = w_headValid && (int'(w_head.dest) == k);
    end
  end

  // Head payload is broadcast; each port only looks at it under its valid.
  always_comb begin
    bus.rid_o   = '0;
    bus.rdata_o = '0;
    bus.rresp_o = '0;
    bus.rlast_o = '0;
    bus.ruser_o = '0;
    for (int k = 0; k < N_TARG_PORT; k++) begin
      bus.rid_o[k]   = w_head.id;
      bus.rdata_o[k] = w_head.data;
      bus.rresp_o[k] = w_head.resp;
      bus.rlast_o[k] = w_head.last;
      bus.ruser_o[k] = w_head.user;
    end
  end

  // Saturating drop counter and sticky routing error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropCnt  <= 8'd0;
      r_routeErr <= 1'b0;
    end else if (w_drop) begin
      if (r_dropCnt != 8'hFF) r_dropCnt <= r_dropCnt + 8'd1;
      r_routeErr <= 1'b1;
    end
  end

  assign bus.drop_cnt_o  = r_dropCnt;
  assign bus.route_err_o = r_routeErr;

endmodule

// File: tb/tb_axi_dr_router.sv
// ---------------------------------------------------------------------------
// tb_axi_dr_router
// Scoreboard bench for axi_dr_router: accepted in-range beats are queued as
// expected results and compared when the router pops them on a target port.
// ---------------------------------------------------------------------------
module tb_axi_dr_router;
  import axi_node_pkg::*;

  localparam int NP = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  axi_dr_router_if #(
    .AXI_ID_IN(4), .AXI_USER_W(6), .AXI_DATA_W(64), .N_TARG_PORT(NP)
  ) bus ();

  axi_dr_router #(
    .AXI_ID_IN(4), .AXI_USER_W(6), .AXI_DATA_W(64), .N_TARG_PORT(NP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cycleCnt   = 0;

  r_beat_t       sbQueue[$];
  logic [NP-1:0] seenValid[$];
  int            seenCycle[$];

  int            monIdx;
  r_beat_t       monExp;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
    end
  endtask

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Scoreboard consumer: every pop on any port must match the oldest
  // expected beat, both in destination and in payload.
  always @(negedge clk) begin
    if (rst_n && (|(bus.rvalid_o & bus.rready_i))) begin
      monIdx = 0;
      for (int k = 0; k < NP; k++) if (bus.rvalid_o[k] & bus.rready_i[k]) monIdx = k;
      if (sbQueue.size() == 0) begin
        checkOutput("sbUnderflow", 128'(1), 128'(0));
      end else begin
        monExp = sbQueue.pop_front();
        checkOutput("validOneHot", 128'(bus.rvalid_o), 128'(7'b1 << monExp.dest));
        checkOutput("payload",
          128'({bus.rid_o[monIdx], bus.rdata_o[monIdx], bus.rresp_o[monIdx],
                bus.rlast_o[monIdx], bus.ruser_o[monIdx]}),
          128'({monExp.id, monExp.data, monExp.resp, monExp.last, monExp.user}));
      end
      seenValid.push_back(bus.rvalid_o);
      seenCycle.push_back(cycleCnt);
    end
  end

  // Drives one beat starting just after a rising edge and returns just after
  // the edge that accepted it; rvalid_i is left high for back-to-back use.
  task automatic applyStimulus(input logic [2:0] dest, input logic [3:0] id,
                               input logic [63:0] data, input logic last,
                               output int waits);
    r_beat_t b;
    b.dest = dest;
    b.id   = id;
    b.data = data;
    b.resp = data[1:0];
    b.last = last;
    b.user = data[9:4];
    bus.rid_i    = {dest, id};
    bus.rdata_i  = data;
    bus.rresp_i  = b.resp;
    bus.rlast_i  = last;
    bus.ruser_i  = b.user;
    bus.rvalid_i = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!bus.rready_o && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.rready_o) begin
      checkOutput("acceptTimeout", 128'(0), 128'(1));
      bus.rvalid_i = 1'b0;
    end else if (int'(dest) < NP) begin
      sbQueue.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    bus.rvalid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    int total;
    logic [NP-1:0] expSeq [4];
    logic [2:0]    dSeq   [4];

    bus.rid_i    = '0;
    bus.rdata_i  = '0;
    bus.rresp_i  = '0;
    bus.rlast_i  = 1'b0;
    bus.ruser_i  = '0;
    bus.rvalid_i = 1'b0;
    bus.rready_i = '1;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstReady",  128'(bus.rready_o),    128'(1));
    checkOutput("rstValid",  128'(bus.rvalid_o),    128'(0));
    checkOutput("rstDrop",   128'(bus.drop_cnt_o),  128'(0));
    checkOutput("rstErr",    128'(bus.route_err_o), 128'(0));
    @(posedge clk);
    #1;

    // Single beat to port 5, visible one cycle after acceptance.
    applyStimulus(3'd5, 4'hA, 64'h0123_4567_89AB_CDEF, 1'b1, w);
    bus.rvalid_i = 1'b0;
    @(negedge clk);
    checkOutput("singleValid", 128'(bus.rvalid_o),   128'(7'b0100000));
    checkOutput("singleId",    128'(bus.rid_o[5]),   128'(4'hA));
    checkOutput("singleLast",  128'(bus.rlast_o[5]), 128'(1));
    @(posedge clk);
    #1;
    idleCycles(2);
    @(negedge clk);
    checkOutput("singleIdle", 128'(bus.rvalid_o), 128'(0));
    @(posedge clk);
    #1;

    // Back-to-back burst to port 2 at full throughput.
    seenValid.delete();
    seenCycle.delete();
    total = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'd2, 4'(i), 64'hB000_0000_0000_0000 + 64'(i * 37), i == 7, w);
      total += w;
    end
    idleCycles(3);
    checkOutput("burstStall", 128'(total), 128'(0));
    checkOutput("burstPops",  128'(seenValid.size()), 128'(8));
    if (seenValid.size() == 8)
      checkOutput("burstSpan", 128'(seenCycle[7] - seenCycle[0]), 128'(7));

    // Stalled port fills the buffer, then drains in order.
    bus.rready_i[2] = 1'b0;
    applyStimulus(3'd2, 4'h3, 64'hC0DE_0000_0000_0011, 1'b0, w);
    applyStimulus(3'd2, 4'h4, 64'hC0DE_0000_0000_0022, 1'b1, w);
    bus.rvalid_i = 1'b0;
    @(negedge clk);
    checkOutput("stallFull",  128'(bus.rready_o), 128'(0));
    checkOutput("stallValid", 128'(bus.rvalid_o), 128'(7'b0000100));
    @(posedge clk);
    #1 bus.rready_i[2] = 1'b1;
    @(negedge clk);
    checkOutput("stallStillFull", 128'(bus.rready_o), 128'(0));
    @(negedge clk);
    checkOutput("stallReopen", 128'(bus.rready_o), 128'(1));
    @(posedge clk);
    #1;
    idleCycles(3);

    // Interleaved destinations on consecutive cycles.
    seenValid.delete();
    seenCycle.delete();
    dSeq[0] = 3'd0; dSeq[1] = 3'd6; dSeq[2] = 3'd0; dSeq[3] = 3'd3;
    expSeq[0] = 7'b0000001; expSeq[1] = 7'b1000000;
    expSeq[2] = 7'b0000001; expSeq[3] = 7'b0001000;
    for (int i = 0; i < 4; i++)
      applyStimulus(dSeq[i], 4'(i + 8), 64'hD000_0000_0000_0000 | 64'(i * 113), 1'b1, w);
    idleCycles(3);
    checkOutput("ilvPops", 128'(seenValid.size()), 128'(4));
    if (seenValid.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("ilvSeq", 128'(seenValid[i]), 128'(expSeq[i]));
        if (i > 0) checkOutput("ilvCycle", 128'(seenCycle[i] - seenCycle[i-1]), 128'(1));
      end
    end

    // Out-of-range destination is dropped and counted.
    applyStimulus(3'd7, 4'h1, 64'hDEAD, 1'b1, w);
    idleCycles(2);
    @(negedge clk);
    checkOutput("dropCnt1",  128'(bus.drop_cnt_o),  128'(1));
    checkOutput("dropErr",   128'(bus.route_err_o), 128'(1));
    checkOutput("dropValid", 128'(bus.rvalid_o),    128'(0));
    checkOutput("dropQueue", 128'(sbQueue.size()),  128'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 299; i++)
      applyStimulus(3'd7, 4'(i), 64'(i), 1'b1, w);
    idleCycles(1);
    @(negedge clk);
    checkOutput("dropSat", 128'(bus.drop_cnt_o), 128'(255));
    @(posedge clk);
    #1;
    applyStimulus(3'd1, 4'h7, 64'h0000_0000_0000_5A5A, 1'b1, w);
    idleCycles(2);
    @(negedge clk);
    checkOutput("errSticky", 128'(bus.route_err_o), 128'(1));
    checkOutput("satHold",   128'(bus.drop_cnt_o),  128'(255));
    @(posedge clk);
    #1;

    // Asynchronous reset with two entries buffered.
    bus.rready_i[4] = 1'b0;
    applyStimulus(3'd4, 4'h2, 64'hE1, 1'b0, w);
    applyStimulus(3'd4, 4'h3, 64'hE2, 1'b1, w);
    bus.rvalid_i = 1'b0;
    @(negedge clk);
    checkOutput("preRstValid", 128'(bus.rvalid_o), 128'(7'b0010000));
    checkOutput("preRstFull",  128'(bus.rready_o), 128'(0));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("asyncValid", 128'(bus.rvalid_o),    128'(0));
    checkOutput("asyncReady", 128'(bus.rready_o),    128'(1));
    checkOutput("asyncDrop",  128'(bus.drop_cnt_o),  128'(0));
    checkOutput("asyncErr",   128'(bus.route_err_o), 128'(0));
    sbQueue.delete();
    bus.rready_i = '1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstValid", 128'(bus.rvalid_o),   128'(0));
    checkOutput("postRstReady", 128'(bus.rready_o),   128'(1));
    checkOutput("postRstDrop",  128'(bus.drop_cnt_o), 128'(0));
    @(posedge clk);
    #1;
    idleCycles(3);
    checkOutput("sbDrained", 128'(sbQueue.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_dr_router.md
Name: axi_DR_router

Overview:
- Read-data return router: takes the R channel coming back from one slave-side master port and steers each beat to the originating target port.
- Destination comes from the upper LOG_N_TARG bits of RID; the node prepends the source port index to the ID on the AR path.
- Registered 2-entry spill buffer decouples the slave-side rready from the target-side rready paths.
- Counterpart of the write-data allocator: N-to-1 mux on W, 1-to-N demux on R.

Parameters:
- AXI_ID_IN, 4, ID width as seen at a target port (RID bits below the routing field).
- AXI_USER_W, 6, RUSER width.
- AXI_DATA_W, 64, RDATA width.
- N_TARG_PORT, 7, number of target ports (need not be a power of two).
- LOG_N_TARG, $clog2(N_TARG_PORT), width of the routing field.
- AXI_ID_OUT, AXI_ID_IN+LOG_N_TARG, RID width on the slave side.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rid_i  in  AXI_ID_OUT  slave-side RID; [AXI_ID_OUT-1:AXI_ID_IN] is the binary destination.
- rdata_i  in  AXI_DATA_W  read data.
- rresp_i  in  2  response.
- rlast_i  in  1  last beat of burst.
- ruser_i  in  AXI_USER_W  user sideband.
- rvalid_i  in  1  slave beat valid.
- rready_o  out  1  router can accept a beat.
- rid_o  out  [N_TARG_PORT][AXI_ID_IN]  RID with routing field stripped (broadcast to all ports).
- rdata_o  out  [N_TARG_PORT][AXI_DATA_W]  broadcast.
- rresp_o  out  [N_TARG_PORT][2]  broadcast.
- rlast_o  out  [N_TARG_PORT]  broadcast.
- ruser_o  out  [N_TARG_PORT][AXI_USER_W]  broadcast.
- rvalid_o  out  N_TARG_PORT  one-hot valid to the destination port.
- rready_i  in  N_TARG_PORT  per-port ready.
- drop_cnt_o  out  8  saturating count of beats with an out-of-range destination.
- route_err_o  out  1  sticky: set on the first dropped beat.

Behaviour:
- Reset (async, rst_n=0): buffer count=0, rd/wr pointers=0, rvalid_o='0, drop_cnt_o=0, route_err_o=0. rready_o=1 once rst_n releases, since it is derived from count. Payload registers need no reset.
- Buffer:
  - 2 entries, each {dest[LOG_N_TARG], id[AXI_ID_IN], data, resp, last, user}.
  - rready_o = (count != 2), taken from registered state only; no combinational path from rready_i.
- Push = rvalid_i & rready_o. Beat is written at wr_ptr and wr_ptr toggles.
- Head = entry at rd_ptr when count>0.
  - rvalid_o[k] = (count>0) & (head.dest==k).
  - Payload outputs carry head fields to every port; valid qualifies them.
- Pop = (count>0) & rready_i[head.dest]; rd_ptr toggles.
- count_next = count + push − pop. Simultaneous push and pop at count=1 keeps count=1, giving full throughput (1 beat/cycle).
- Latency: a beat accepted at edge t is visible on rvalid_o from t+1. Minimum 1 cycle, no combinational feed-through.
- Out-of-range destination (dest >= N_TARG_PORT, possible when N is not a power of 2):
  - The beat is accepted (rready_o as normal) but never written.
  - drop_cnt_o increments, saturating at 255; route_err_o sets.
- Order is preserved across all ports. Head-of-line blocking by a stalled port is accepted by design, because AXI ordering per slave is handled upstream.
- AXI stability:
  - Once rvalid_o[k] is high, payload and valid hold until popped; the buffer guarantees this.
  - rlast is carried unmodified; the router has no burst lock (interleaving across IDs is legal).
- Reset mid-burst: all entries are discarded immediately and the counters clear. Upstream must be reset in the same domain.

Decomposition:
- Shared package axi_node_pkg holds:
  - the R beat struct type, parameterised through widths passed as localparams;
  - the constant RESP width = 2.
- Natural sub-module: axi_r_spill_buffer, a 2-entry generic valid/ready buffer of width DATA_WIDTH.
  - The router instantiates it with width LOG_N_TARG+AXI_ID_IN+AXI_DATA_W+2+1+AXI_USER_W.
  - The router adds the destination decode, one-hot valid and drop logic.

Test Plan:
- Single beat, rid_i={3'd5,4'hA}, rlast_i=1, all rready_i=1 → next cycle rvalid_o=7'b0100000, rid_o[5]=4'hA, rlast_o[5]=1, then idle.
- Back-to-back 8-beat burst to port 2 with rready_i[2]=1 → rready_o stays 1, 8 consecutive rvalid_o[2] pulses, data in order, count never reaches 2.
- Port 2 stalled (rready_i[2]=0) while beats stream → after 2 accepts rready_o=0. Release rready_i[2] → drains in order, rready_o returns to 1 the cycle after the first pop.
- Interleaved destinations 0,6,0,3 with all ready → rvalid_o sequence 0000001, 1000000, 0000001, 0001000 on consecutive cycles.
- rid_i routing field = 7 with N_TARG_PORT=7 → beat accepted, no rvalid_o, drop_cnt_o=1, route_err_o=1. 300 such beats → drop_cnt_o=255.
- Assert rst_n=0 with 2 entries buffered → rvalid_o='0 immediately (asynchronous). After release rready_o=1, count=0, drop_cnt_o=0.
